// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: Gray read pointers, RAM fetch on !EMPTY,
// and a 2-entry first-word-fall-through output buffer with valid/ready handshake.
module async_fifo_rd_ctrl #(
    parameter int C_DEPTH_BITS = 10,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    RD_CLK,
    input  logic                    wDirClr,
    input  logic                    EMPTY,
    output logic [C_DEPTH_BITS-1:0] RD_PTR,
    output logic [C_DEPTH_BITS-1:0] RD_PTR_P1,
    output logic                    RD_VALID,
    output logic                    RAM_RD_EN,
    output logic [C_DEPTH_BITS-1:0] RAM_RD_ADDR,
    input  logic [C_DATA_WIDTH-1:0] RAM_RD_DATA,
    output logic [C_DATA_WIDTH-1:0] DOUT,
    output logic                    DOUT_VALID,
    input  logic                    DOUT_READY
);

    function automatic logic [C_DEPTH_BITS-1:0] gray(input logic [C_DEPTH_BITS-1:0] x);
        return x ^ (x >> 1);
    endfunction

    logic [C_DEPTH_BITS-1:0] bin_q, bin_d, bin_p1_d;
    logic [C_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_p1_q;
    logic                    rd_valid_q;
    logic                    in_fl_q;
    logic [1:0]              occ_q, occ_d;
    logic                    hd_q, hd_d;
    logic                    tail;
    logic [C_DATA_WIDTH-1:0] ob_q [2];
    logic [1:0]              cnt;
    logic                    pop, fetch, wr;

    always_comb begin
        cnt      = occ_q + {1'b0, in_fl_q};
        pop      = (occ_q != 2'd0) & DOUT_READY;
        fetch    = ~EMPTY & ~wDirClr & ((cnt < 2'd2) | pop);
        // The word fetched last cycle is on RAM_RD_DATA now; the credit rule keeps occ_q < 2 here.
        wr       = in_fl_q;
        tail     = hd_q ^ occ_q[0];
        bin_d    = bin_q + {{(C_DEPTH_BITS-1){1'b0}}, fetch};
        bin_p1_d = bin_d + {{(C_DEPTH_BITS-1){1'b0}}, 1'b1};
        hd_d     = hd_q ^ pop;
        occ_d    = occ_q;
        case ({wr, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge RD_CLK or posedge wDirClr) begin
        if (wDirClr) begin
            bin_q       <= '0;
            rd_ptr_q    <= '0;
            rd_ptr_p1_q <= {{(C_DEPTH_BITS-1){1'b0}}, 1'b1};
            rd_valid_q  <= 1'b0;
            in_fl_q     <= 1'b0;
            occ_q       <= '0;
            hd_q        <= 1'b0;
            ob_q[0]     <= '0;
            ob_q[1]     <= '0;
        end else begin
            bin_q       <= bin_d;
            rd_ptr_q    <= gray(bin_d);
            rd_ptr_p1_q <= gray(bin_p1_d);
            rd_valid_q  <= fetch;
            in_fl_q     <= fetch;
            occ_q       <= occ_d;
            hd_q        <= hd_d;
            if (wr) ob_q[tail] <= RAM_RD_DATA;
        end
    end

    assign RD_PTR      = rd_ptr_q;
    assign RD_PTR_P1   = rd_ptr_p1_q;
    assign RD_VALID    = rd_valid_q;
    assign RAM_RD_EN   = fetch;
    assign RAM_RD_ADDR = bin_q;
    assign DOUT        = ob_q[hd_q];
    assign DOUT_VALID  = (occ_q != 2'd0);

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
- Read-side controller for the async FIFO; the counterpart of the write-side pointer logic.
- Owns the Gray-coded read pointers (RD_PTR, RD_PTR_P1) that the full/empty comparator consumes.
- Fetches words from the dual-port RAM read port using the comparator's EMPTY flag.
- Presents data to the consumer as a first-word-fall-through (FWFT) valid/ready stream through a 2-entry output buffer.

Parameters:
- C_DEPTH_BITS, 10: pointer and RAM address width; FIFO depth = 2^C_DEPTH_BITS. Minimum 3.
- C_DATA_WIDTH, 32: data word width.

Ports:
- RD_CLK  input  1  read-domain clock; all state changes on the rising edge.
- wDirClr  input  1  reset: asynchronous, active-high; clock RD_CLK.
- EMPTY  input  1  empty flag from the comparator, synchronous to RD_CLK.
- RD_PTR  output  C_DEPTH_BITS  registered Gray read pointer (address of the next word to fetch).
- RD_PTR_P1  output  C_DEPTH_BITS  registered Gray code of the read pointer + 1.
- RD_VALID  output  1  registered read strobe to the comparator.
- RAM_RD_EN  output  1  RAM read enable.
- RAM_RD_ADDR  output  C_DEPTH_BITS  binary RAM read address.
- RAM_RD_DATA  input  C_DATA_WIDTH  RAM read data, valid 1 cycle after RAM_RD_EN.
- DOUT  output  C_DATA_WIDTH  head word of the output buffer.
- DOUT_VALID  output  1  output buffer is non-empty.
- DOUT_READY  input  1  consumer accepts DOUT.

Behaviour:
- Reset (wDirClr=1, asynchronous), all registers return to:
  - rBin=0, RD_PTR=0, RD_PTR_P1=1, RD_VALID=0.
  - Buffer occupancy occ=0, in-flight flag rInFl=0, DOUT_VALID=0, DOUT=0.
  - RAM_RD_EN is forced to 0 while wDirClr is high.
- Pointer:
  - rBin is a binary counter that wraps modulo 2^C_DEPTH_BITS (all-ones to 0).
  - RD_PTR = gray(rBin) and RD_PTR_P1 = gray(rBin+1), where gray(x) = x ^ (x>>1). Both are registered and updated in the same edge as rBin.
  - RAM_RD_ADDR = rBin, combinational from the register.
- Credit:
  - cnt = occ + rInFl, range 0..2.
  - pop = DOUT_VALID & DOUT_READY.
  - fetch = !EMPTY & !wDirClr & (cnt<2 | pop).
  - RAM_RD_EN = fetch, combinational.
- On a fetch edge:
  - rBin increments.
  - rInFl is set to 1.
  - RD_VALID is set to 1; RD_VALID = registered fetch, so it is high exactly one cycle after each fetch.
  - RD_VALID has no combinational path from EMPTY, which avoids a loop through the comparator's early-empty term.
- Data return:
  - In the cycle after a fetch, RAM_RD_DATA is written into the buffer tail at the edge, and rInFl clears unless a new fetch happens in that same cycle.
  - Latency from a fetch cycle to DOUT_VALID high is 2 cycles.
- Output buffer (2-entry FIFO):
  - DOUT is the head entry.
  - A pop advances the head. A simultaneous pop and write keeps occ unchanged.
  - The credit rule guarantees a write never arrives when occ=2; the bench asserts this.
- Throughput: with EMPTY=0 and DOUT_READY=1 held, fetch is issued every cycle and DOUT_VALID stays high continuously after the initial 2-cycle latency.
- Backpressure: with DOUT_READY=0, at most 2 words are fetched; RAM_RD_EN then stays low until a pop.
- EMPTY rising: fetch stops in the same cycle. An in-flight word still lands and is delivered.
- Reset mid-operation: an in-flight word and all buffered words are discarded, and the RAM_RD_DATA of the following cycle is ignored. The pointer returns to 0, so the writer side must be reset together with this block.
- DOUT holds its value while DOUT_VALID=1 and DOUT_READY=0. This is AXI-stream style stability: once asserted, DOUT_VALID never drops without a pop.

Test Plan:
- Reset check: assert wDirClr asynchronously between edges -> RD_PTR=0, RD_PTR_P1=1, RD_VALID=0, DOUT_VALID=0, RAM_RD_EN=0 immediately.
- Single word: EMPTY low for 1 cycle at t0 with RAM word 0xA5A5_0001 -> RAM_RD_EN=1 at t0, RAM_RD_ADDR=0 at t0, RD_VALID=1 at t1, RD_PTR=1 at t1, DOUT_VALID=1 with DOUT=0xA5A5_0001 at t2.
- Streaming: EMPTY=0 and DOUT_READY=1 for 20 cycles -> 20 consecutive fetches; DOUT carries 0..19 in order on consecutive cycles, with no bubbles after latency 2.
- Backpressure: DOUT_READY=0, EMPTY=0 -> exactly 2 fetches and then RAM_RD_EN=0. Release DOUT_READY for 1 cycle -> one pop and one new fetch in the same cycle; occ never exceeds 2.
- Wrap: C_DEPTH_BITS=3, 9 fetches -> RD_PTR sequence is 0,1,3,2,6,7,5,4,0,1, RAM_RD_ADDR wraps 7 to 0, and RD_PTR_P1 is always one Gray step ahead.
- Mid-stream reset: assert wDirClr one cycle after a fetch while occ=1 -> DOUT_VALID=0, the returning RAM word is dropped, and after release the first word fetched is from address 0.
